// File: rtl/cell_pos_pkg.sv
// Shared types and constants for the per-cell position reader.
// Memory layout: count at address 0, particle positions {posz,posy,posx} from address 1.
package cell_pos_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    WAIT_CNT,
    STREAM,
    DRAIN,
    FIN
  } state_t;

  localparam int COUNT_ADDR          = 0;
  localparam int FIRST_PARTICLE_ADDR = 1;

  localparam int DEFAULT_DATA_WIDTH = 96;
  localparam int POS_WIDTH          = 32;
  localparam int POSX_LO            = 0;
  localparam int POSY_LO            = 32;
  localparam int POSZ_LO            = 64;

endpackage

// File: rtl/pos_skid_fifo.sv
// Synchronous FIFO of {pid, pos} entries that absorbs memory read latency.
// Push and pop in the same cycle are both honoured, even when full.
module pos_skid_fifo #(
  parameter  int WIDTH = 104,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTRW-1:0] bump(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/cell_pos_reader.sv
// Read sequencer for one per-cell position memory: reads the count,
// then streams every particle position to a valid/ready consumer.
module cell_pos_reader
  import cell_pos_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = CW + 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] MAX_CNT  = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ADDR = ADDR_WIDTH'(COUNT_ADDR);
  localparam logic [ADDR_WIDTH-1:0] FIRST    = ADDR_WIDTH'(FIRST_PARTICLE_ADDR);

  state_t                state;
  logic                  wait_cnt;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  s1_v;
  logic                  s2_v;
  logic [ADDR_WIDTH-1:0] s1_pid;
  logic [ADDR_WIDTH-1:0] s2_pid;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [EW-1:0]         head;
  logic [PW-1:0]         pend;
  logic                  can_issue;
  logic [ADDR_WIDTH-1:0] raw_cnt;
  logic [ADDR_WIDTH-1:0] clamp_cnt;

  assign raw_cnt   = rd_data[ADDR_WIDTH-1:0];
  assign clamp_cnt = (raw_cnt > MAX_CNT) ? MAX_CNT : raw_cnt;

  assign busy      = (state != IDLE);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign {out_pid, out_pos} = head;
  assign out_last  = out_valid && (out_pid == count);

  // Slots owed to reads on the bus, in the pipe or queued, after this pop.
  assign pend = PW'(rd_en) + PW'(s1_v) + PW'(s2_v)
              + PW'(fifo_count) - PW'(pop);
  assign can_issue = (pend < PW'(FIFO_DEPTH)) && (!fifo_full || pop);

  pos_skid_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .rst_n     (rst_n),
    .push      (s2_v),
    .push_data ({s2_pid, rd_data}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The count read is excluded; only particle reads enter the pipe.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s1_pid <= '0;
      s2_pid <= '0;
    end else begin
      s1_v   <= rd_en && (state != RD_CNT);
      s2_v   <= s1_v;
      s1_pid <= rd_addr;
      s2_pid <= s1_pid;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      count     <= '0;
      count_err <= 1'b0;
      next_addr <= '0;
      wait_cnt  <= 1'b0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= RD_CNT;
            count_err <= 1'b0;
            rd_en     <= 1'b1;
            rd_addr   <= CNT_ADDR;
          end
        end
        RD_CNT: begin
          state    <= WAIT_CNT;
          wait_cnt <= 1'b0;
        end
        WAIT_CNT: begin
          if (!wait_cnt) begin
            wait_cnt <= 1'b1;
          end else begin
            count     <= clamp_cnt;
            count_err <= (raw_cnt > MAX_CNT);
            if (clamp_cnt == '0) begin
              state <= FIN;
            end else begin
              rd_en     <= 1'b1;
              rd_addr   <= FIRST;
              next_addr <= FIRST + ADDR_WIDTH'(1);
              state     <= (clamp_cnt == FIRST) ? DRAIN : STREAM;
            end
          end
        end
        STREAM: begin
          if (can_issue) begin
            rd_en     <= 1'b1;
            rd_addr   <= next_addr;
            next_addr <= next_addr + ADDR_WIDTH'(1);
            if (next_addr == count) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pend == '0) begin
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_pos_reader.sv
// Directed bench for cell_pos_reader with a 2-cycle-latency memory model.
// Beats, reads and done pulses are logged on the falling edge.
module tb_cell_pos_reader;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [7:0]  count;
  logic        count_err;
  logic [7:0]  rd_addr;
  logic        rd_en;
  logic [95:0] rd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [95:0] out_pos;
  logic [7:0]  out_pid;
  logic        out_last;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;

  logic [95:0] mem [256];
  logic [95:0] q1 = '0;

  int          beat_pid [$];
  logic [95:0] beat_pos [$];
  bit          beat_last[$];
  int          beat_cyc [$];
  int          rd_q     [$];
  int          done_n    = 0;
  int          done_cyc  = 0;
  bit          done_busy = 1'b0;
  bit          valid_seen = 1'b0;

  cell_pos_reader dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .count_err (count_err),
    .rd_addr   (rd_addr),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pos   (out_pos),
    .out_pid   (out_pid),
    .out_last  (out_last)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (rd_en) q1 <= mem[rd_addr];
    rd_data <= q1;
  end

  always @(negedge clock) begin
    if (rst_n) begin
      if (out_valid) valid_seen = 1'b1;
      if (out_valid && out_ready) begin
        beat_pid.push_back(int'(out_pid));
        beat_pos.push_back(out_pos);
        beat_last.push_back(out_last);
        beat_cyc.push_back(cyc);
      end
      if (rd_en) rd_q.push_back(int'(rd_addr));
      if (done) begin
        done_n++;
        done_cyc  = cyc;
        done_busy = busy;
      end
    end
  end

  function automatic logic [95:0] pat(input int i);
    return {i * 7 + 256, ~i, i};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    beat_pid.delete();
    beat_pos.delete();
    beat_last.delete();
    beat_cyc.delete();
    rd_q.delete();
    done_n     = 0;
    valid_seen = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int i = 0;
    while (done_n == 0 && i < budget) begin
      @(posedge clock);
      i++;
    end
    #1;
    chk({tag, "_done"}, done_n, 1);
  endtask

  task automatic check_stream(input int n, input string tag);
    int lasts = 0;
    chk({tag, "_beats"}, beat_pid.size(), n);
    for (int k = 0; k < beat_pid.size() && k < n; k++) begin
      chk({tag, "_pid"}, beat_pid[k], k + 1);
      chk({tag, "_pos"}, beat_pos[k], pat(k + 1));
      if (beat_last[k]) lasts++;
    end
    chk({tag, "_last_n"}, lasts, 1);
    if (beat_last.size() == n) chk({tag, "_last_end"}, beat_last[n-1], 1);
  endtask

  task automatic idle_gap();
    repeat (3) @(posedge clock);
    #1;
    clear_mon();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pat(i);

    // reset values
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rden", rd_en, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_err", count_err, 0);
    chk("rst_pos", out_pos, 0);
    chk("rst_pid", out_pid, 0);
    chk("rst_last", out_last, 0);
    rst_n = 1'b1;
    idle_gap();

    // three particles, consumer always ready
    mem[0] = 96'd3;
    pulse_start();
    chk("t1_busy", busy, 1);
    wait_done(60, "t1");
    chk("t1_rd_n", rd_q.size(), 4);
    for (int k = 0; k < rd_q.size() && k < 4; k++) chk("t1_rd_addr", rd_q[k], k);
    check_stream(3, "t1");
    for (int k = 0; k < beat_cyc.size() && k < 3; k++)
      chk("t1_beat_cyc", beat_cyc[k], t0 + 6 + k);
    chk("t1_done_cyc", done_cyc, t0 + 10);
    chk("t1_done_busy", done_busy, 0);
    chk("t1_count", count, 3);
    idle_gap();
    chk("t1_one_done", done_n, 0);

    // empty cell
    mem[0] = {88'hA5A5, 8'd0};
    pulse_start();
    wait_done(60, "t2");
    chk("t2_valid", valid_seen, 0);
    chk("t2_rd_n", rd_q.size(), 1);
    if (rd_q.size() > 0) chk("t2_rd_addr", rd_q[0], 0);
    chk("t2_done_cyc", done_cyc, t0 + 4);
    chk("t2_count", count, 0);
    chk("t2_err", count_err, 0);
    idle_gap();

    // backpressure: 20 stalled cycles, then drain
    mem[0] = 96'd10;
    out_ready = 1'b0;
    pulse_start();
    repeat (20) @(posedge clock);
    #1;
    chk("t3_stall_reads", rd_q.size() - 1, 4);
    chk("t3_stall_beats", beat_pid.size(), 0);
    chk("t3_stall_valid", out_valid, 1);
    chk("t3_stall_pid", out_pid, 1);
    out_ready = 1'b1;
    wait_done(100, "t3");
    check_stream(10, "t3");
    chk("t3_rd_n", rd_q.size(), 11);
    idle_gap();

    // toggling ready
    out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 200 && done_n == 0; i++) begin
      @(posedge clock);
      #1 out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    wait_done(20, "t3t");
    check_stream(10, "t3t");
    idle_gap();

    // oversize count is clamped
    mem[0] = {88'h123456, 8'd255};
    pulse_start();
    wait_done(400, "t4");
    chk("t4_count", count, 219);
    chk("t4_err", count_err, 1);
    check_stream(219, "t4");
    idle_gap();
    chk("t4_err_sticky", count_err, 1);
    mem[0] = 96'd2;
    pulse_start();
    chk("t4_err_clr", count_err, 0);
    wait_done(60, "t4b");
    chk("t4b_count", count, 2);
    check_stream(2, "t4b");
    idle_gap();

    // reset during beat 5 of 10
    mem[0] = 96'd10;
    pulse_start();
    repeat (10) @(posedge clock);
    #1;
    chk("t5_pre_pid", out_pid, 5);
    rst_n = 1'b0;
    @(posedge clock);
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_rden", rd_en, 0);
    chk("t5_addr", rd_addr, 0);
    chk("t5_count", count, 0);
    chk("t5_pid", out_pid, 0);
    chk("t5_pos", out_pos, 0);
    chk("t5_last", out_last, 0);
    chk("t5_done", done, 0);
    rst_n = 1'b1;
    clear_mon();
    repeat (6) @(posedge clock);
    #1;
    chk("t5_quiet", beat_pid.size() + rd_q.size() + done_n, 0);
    clear_mon();
    pulse_start();
    wait_done(60, "t5b");
    check_stream(10, "t5b");
    idle_gap();

    // second start mid-sweep is ignored
    mem[0] = 96'd6;
    pulse_start();
    repeat (5) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(60, "t6");
    check_stream(6, "t6");
    repeat (10) @(posedge clock);
    #1;
    chk("t6_one_done", done_n, 1);
    chk("t6_idle", busy, 0);
    chk("t6_rd_n", rd_q.size(), 7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
